// File: rtl/tnoc_output_port_controller.sv
// Per-output-port switch allocator: wormhole-locks each output VC to one input
// port and selects, cycle by cycle, which owned VC/port drives the output link.
module tnoc_output_port_controller #(
  parameter int CHANNELS = 2,
  parameter int PORTS    = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PORTS*CHANNELS-1:0] i_request,
  input  logic [PORTS*CHANNELS-1:0] i_free,
  input  logic [PORTS*CHANNELS-1:0] i_start_of_packet,
  input  logic [PORTS*CHANNELS-1:0] i_end_of_packet,
  input  logic [CHANNELS-1:0]       i_vc_available,
  output logic [PORTS*CHANNELS-1:0] o_grant,
  output logic [PORTS-1:0]          o_port_select,
  output logic [CHANNELS-1:0]       o_vc_select
);

  localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } vc_state_e;

  logic [CHANNELS-1:0] vc_eligible;
  logic [CHANNELS-1:0] vc_free;
  logic [PORTS-1:0]    grant_col [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_vc
    vc_state_e        state_q;
    logic [PW-1:0]    owner_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [PORTS-1:0] grant_q;
    logic [PORTS-1:0] req_vec;
    logic [PORTS-1:0] head_vec;
    logic [PORTS-1:0] tail_vec;
    logic [PORTS-1:0] free_vec;
    logic             win_vld;
    logic [PW-1:0]    win_port;
    logic [PW-1:0]    scan_port;

    for (genvar pi = 0; pi < PORTS; pi++) begin : gen_port
      assign req_vec[pi]  = i_request[pi*CHANNELS+gi];
      assign head_vec[pi] = i_request[pi*CHANNELS+gi] & i_start_of_packet[pi*CHANNELS+gi];
      assign tail_vec[pi] = i_end_of_packet[pi*CHANNELS+gi];
      assign free_vec[pi] = i_free[pi*CHANNELS+gi];
      assign o_grant[pi*CHANNELS+gi] = grant_q[pi];
    end

    // Round-robin over head requests, starting just after the last winner.
    always_comb begin
      win_vld   = 1'b0;
      win_port  = '0;
      scan_port = '0;
      for (int i = 1; i <= PORTS; i++) begin
        scan_port = PW'((int'(rr_ptr_q) + i) % PORTS);
        if (!win_vld && head_vec[scan_port]) begin
          win_vld  = 1'b1;
          win_port = scan_port;
        end
      end
    end

    // Grant is held for the whole packet; only the owner's tail releases it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        owner_q  <= '0;
        rr_ptr_q <= PW'(PORTS - 1);
        grant_q  <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (win_vld && i_vc_available[gi]) begin
              state_q  <= BUSY;
              owner_q  <= win_port;
              rr_ptr_q <= win_port;
              grant_q  <= PORTS'(1) << win_port;
            end
          end
          BUSY: begin
            if (tail_vec[owner_q]) begin
              state_q <= IDLE;
              grant_q <= '0;
            end
          end
          default: begin
            state_q <= IDLE;
            grant_q <= '0;
          end
        endcase
      end
    end

    assign vc_eligible[gi] = (state_q == BUSY) & req_vec[owner_q];
    assign vc_free[gi]     = free_vec[owner_q];
    assign grant_col[gi]   = grant_q;
  end

  logic [CW-1:0] link_ptr_q;
  logic [CW-1:0] link_ptr_d;
  logic [CW-1:0] sel_vc;
  logic [CW-1:0] scan_vc;
  logic          sel_vld;

  always_comb begin
    sel_vld = 1'b0;
    sel_vc  = '0;
    scan_vc = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      scan_vc = CW'((int'(link_ptr_q) + i) % CHANNELS);
      if (!sel_vld && vc_eligible[scan_vc]) begin
        sel_vld = 1'b1;
        sel_vc  = scan_vc;
      end
    end
  end

  // Pointer only moves on an accepted flit, so a stalled VC keeps the link.
  assign link_ptr_d = (sel_vld && vc_free[sel_vc]) ? sel_vc : link_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_ptr_q <= CW'(CHANNELS - 1);
    end else begin
      link_ptr_q <= link_ptr_d;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : gen_vsel
    assign o_vc_select[gi] = sel_vld && (sel_vc == CW'(gi));
  end

  always_comb begin
    o_port_select = '0;
    for (int v = 0; v < CHANNELS; v++) begin
      if (o_vc_select[v]) begin
        o_port_select = o_port_select | grant_col[v];
      end
    end
  end

endmodule

// File: tb/tb_tnoc_output_port_controller.sv
// Directed bench for tnoc_output_port_controller (PORTS=5, CHANNELS=2).
// Bit index of port p, VC v is p*2+v.
module tb_tnoc_output_port_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] req, fre, sop, eop;
  logic [1:0] vca;
  logic [9:0] grant;
  logic [4:0] psel;
  logic [1:0] vsel;

  int checks = 0;
  int errors = 0;
  int cnt [5];
  logic [9:0] exp_grant [16];
  logic [1:0] exp_vsel [8];
  logic [4:0] exp_psel [8];

  always #5 clk = ~clk;

  tnoc_output_port_controller #(
    .CHANNELS(2),
    .PORTS   (5)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_request        (req),
    .i_free           (fre),
    .i_start_of_packet(sop),
    .i_end_of_packet  (eop),
    .i_vc_available   (vca),
    .o_grant          (grant),
    .o_port_select    (psel),
    .o_vc_select      (vsel)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req = '0;
    fre = '0;
    sop = '0;
    eop = '0;
  endtask

  initial begin
    clear_inputs();
    vca = 2'b11;
    for (int p = 0; p < 5; p++) cnt[p] = 0;
    exp_grant = '{10'h000, 10'h002, 10'h002, 10'h002, 10'h000, 10'h008, 10'h008, 10'h008,
                  10'h000, 10'h080, 10'h080, 10'h080, 10'h000, 10'h002, 10'h002, 10'h002};
    exp_vsel  = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b01};
    exp_psel  = '{5'h08, 5'h01, 5'h08, 5'h01, 5'h08, 5'h08, 5'h08, 5'h01};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_psel", 32'(psel), 32'h0);
    chk("reset_vsel", 32'(vsel), 32'h0);
    rst_n = 1'b1;
    step();

    // Single-flit packet, port 2 VC0
    req[4] = 1'b1;
    sop[4] = 1'b1;
    #1;
    chk("t1_grant_n", 32'(grant), 32'h0);
    step();
    fre[4] = 1'b1;
    eop[4] = 1'b1;
    #1;
    chk("t1_grant_n1", 32'(grant), 32'h010);
    chk("t1_psel_n1", 32'(psel), 32'h04);
    chk("t1_vsel_n1", 32'(vsel), 32'h1);
    step();
    clear_inputs();
    #1;
    chk("t1_grant_n2", 32'(grant), 32'h0);
    chk("t1_psel_n2", 32'(psel), 32'h0);
    chk("t1_vsel_n2", 32'(vsel), 32'h0);

    // Round-robin fairness on VC1: ports 0,1,3 with 3-flit packets
    for (int k = 0; k < 16; k++) begin
      clear_inputs();
      for (int p = 0; p < 5; p++) begin
        if (p == 0 || p == 1 || p == 3) begin
          req = req | (10'(1) << (p*2+1));
          if (cnt[p] == 0) sop = sop | (10'(1) << (p*2+1));
        end
      end
      #1;
      for (int p = 0; p < 5; p++) begin
        if (vsel == 2'b10 && ((psel >> p) & 5'd1) != 5'd0) begin
          fre = fre | (10'(1) << (p*2+1));
          if (cnt[p] == 2) eop = eop | (10'(1) << (p*2+1));
          cnt[p] = (cnt[p] + 1) % 3;
        end
      end
      #1;
      chk($sformatf("t2_grant_c%0d", k), 32'(grant), 32'(exp_grant[k]));
      step();
    end
    clear_inputs();
    #1;
    chk("t2_grant_end", 32'(grant), 32'h0);
    step();

    // VC availability gating, port 4 VC0
    vca = 2'b10;
    req[8] = 1'b1;
    sop[8] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("t3_gated_c%0d", k), 32'(grant), 32'h0);
      step();
    end
    vca = 2'b11;
    #1;
    chk("t3_avail_rise", 32'(grant), 32'h0);
    step();
    vca = 2'b10;
    fre[8] = 1'b1;
    #1;
    chk("t3_grant", 32'(grant), 32'h100);
    chk("t3_psel", 32'(psel), 32'h10);
    chk("t3_vsel", 32'(vsel), 32'h1);
    step();
    sop[8] = 1'b0;
    #1;
    chk("t3_hold_unavail", 32'(grant), 32'h100);
    step();
    eop[8] = 1'b1;
    #1;
    chk("t3_tail", 32'(grant), 32'h100);
    step();
    clear_inputs();
    vca = 2'b11;
    #1;
    chk("t3_release", 32'(grant), 32'h0);
    step();

    // Two VCs, two owners: port 0 on VC0, port 3 on VC1
    req = 10'h081;
    sop = 10'h081;
    #1;
    chk("t4_grant_pre", 32'(grant), 32'h0);
    step();
    sop = '0;
    #1;
    chk("t4_grant", 32'(grant), 32'h081);
    for (int j = 0; j < 8; j++) begin
      fre = (j == 4 || j == 5) ? 10'h001 : 10'h081;
      #1;
      chk($sformatf("t4_vsel_c%0d", j), 32'(vsel), 32'(exp_vsel[j]));
      chk($sformatf("t4_psel_c%0d", j), 32'(psel), 32'(exp_psel[j]));
      step();
    end
    fre = 10'h081;
    eop = 10'h081;
    #1;
    chk("t4_grant_tail", 32'(grant), 32'h081);
    step();
    clear_inputs();
    #1;
    chk("t4_release", 32'(grant), 32'h0);
    step();

    // Spurious tail from port 2 during port 1's packet on VC0
    req[2] = 1'b1;
    sop[2] = 1'b1;
    #1;
    chk("t5_grant_pre", 32'(grant), 32'h0);
    step();
    sop[2] = 1'b0;
    fre[2] = 1'b1;
    eop[4] = 1'b1;
    #1;
    chk("t5_grant", 32'(grant), 32'h004);
    step();
    #1;
    chk("t5_spurious_hold", 32'(grant), 32'h004);
    step();
    eop = 10'h004;
    #1;
    chk("t5_owner_tail", 32'(grant), 32'h004);
    step();
    clear_inputs();
    #1;
    chk("t5_release", 32'(grant), 32'h0);
    step();

    // Reset mid-packet with VC0 and VC1 busy
    req = 10'h081;
    sop = 10'h081;
    #1;
    chk("t6_grant_pre", 32'(grant), 32'h0);
    step();
    sop = '0;
    fre = 10'h081;
    #1;
    chk("t6_grant_busy", 32'(grant), 32'h081);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("t6_async_grant", 32'(grant), 32'h0);
    chk("t6_async_psel", 32'(psel), 32'h0);
    chk("t6_async_vsel", 32'(vsel), 32'h0);
    step();
    chk("t6_reset_edge", 32'(grant), 32'h0);
    rst_n = 1'b1;
    req = 10'h101;
    sop = 10'h101;
    #1;
    chk("t6_post_pre", 32'(grant), 32'h0);
    step();
    fre = 10'h001;
    eop = 10'h001;
    #1;
    chk("t6_post_grant", 32'(grant), 32'h001);
    chk("t6_post_psel", 32'(psel), 32'h01);
    chk("t6_post_vsel", 32'(vsel), 32'h1);
    step();
    req = 10'h100;
    sop = 10'h100;
    fre = '0;
    eop = '0;
    #1;
    chk("t6_bubble", 32'(grant), 32'h0);
    step();
    #1;
    chk("t6_second_grant", 32'(grant), 32'h100);
    step();
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tnoc_output_port_controller.md
Name: tnoc_output_port_controller

Overview:
Per-output-port switch allocator. One instance sits beside each output port of the router. It collects the per-VC request, free, start_of_packet and end_of_packet signals that the route selectors of all 5 input ports drive toward this output. It grants each output VC to one input port for a whole packet (wormhole lock) and picks, cycle by cycle, which input port's flit drives the shared output link.

Parameters:
CHANNELS, 2, number of virtual channels (1..8)
PORTS, 5, number of input ports competing for this output

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
i_request  input  PORTS*CHANNELS  flit valid toward this output; bit index p*CHANNELS+v (p = input port, v = VC)
i_free  input  PORTS*CHANNELS  flit accepted (valid & ready) at requester p, VC v
i_start_of_packet  input  PORTS*CHANNELS  head flit present at p,v
i_end_of_packet  input  PORTS*CHANNELS  tail flit accepted at p,v
i_vc_available  input  CHANNELS  downstream VC v can accept a new packet
o_grant  output  PORTS*CHANNELS  VC v of this output is owned by input p; registered
o_port_select  output  PORTS  one-hot; input port driving the output link this cycle; all-zero = none
o_vc_select  output  CHANNELS  one-hot; VC carried on the link this cycle

Behaviour:
- Reset: o_grant = 0 and all VC FSMs = IDLE. Every round-robin pointer resets so that port 0 (packet arbiter) or VC 0 (link arbiter) has highest priority next. o_port_select and o_vc_select are 0 while no grant exists.
- One packet FSM per VC v, with states IDLE and BUSY. A state register owner[v] holds an encoded input port.
- IDLE → BUSY: at least one p has i_request[p,v] & i_start_of_packet[p,v], and i_vc_available[v]=1.
  - The winner is chosen by round-robin, scanning from port (rr_ptr[v]+1) mod PORTS upward.
  - On the following edge: owner[v] <= winner, rr_ptr[v] <= winner, and o_grant[winner,v] becomes 1.
  - Latency: request seen in cycle N → grant visible in cycle N+1.
- BUSY holds: o_grant[owner,v] stays 1 regardless of i_vc_available or request withdrawal.
- BUSY → IDLE: i_end_of_packet[owner,v]=1. o_grant[owner,v] clears on the next edge.
  - The IDLE cycle always evaluates arbitration, so back-to-back packets on one VC incur exactly one bubble cycle.
  - i_end_of_packet from a non-owner is ignored.
- Single-flit packet: start and end occur in the same granted cycle. The FSM returns to IDLE after that one cycle.
- At most one bit of o_grant is set per VC column. Different VCs may be owned by different ports at once.
- Link arbitration is combinational from the registered state:
  - Eligible VCs are those with state BUSY and i_request[owner[v],v]=1.
  - Pick one eligible VC by round-robin from (link_ptr+1) mod CHANNELS.
  - Drive o_vc_select = that VC and o_port_select = onehot(owner[v]). With no eligible VC, both outputs are 0.
  - link_ptr updates to the selected VC only when i_free[owner,v]=1 for it. A stalled flit keeps the link, so there is no flit interleave during backpressure.
- CHANNELS=1: link arbitration degenerates; o_vc_select equals the BUSY state of VC0 ANDed with the owner's request.
- Reset asserted mid-packet: all grants drop immediately (asynchronously) and all state returns to reset values. Upstream flits in flight are the upstream's responsibility.
- No combinational path from inputs to o_grant.

Test Plan:
- Single request, single-flit packet: PORTS=5, CHANNELS=2, port 2 VC0 head+tail, vc_available=2'b11.
  - Required: o_grant bit 4 high in cycle N+1 only.
  - Required: o_port_select=5'b00100 and o_vc_select=2'b01 in that cycle; all zero from N+2.
- Round-robin fairness: ports 0, 1, 3 continuously request VC1 with 3-flit packets.
  - Required: grant order 0 → 1 → 3 → 0.
  - Required: one bubble cycle between packets; each grant held exactly 3 accepted flits.
- VC availability gating: port 4 requests VC0 while i_vc_available=2'b10.
  - Required: no grant while gated; grant appears 1 cycle after vc_available[0] rises.
  - Required: later dropping vc_available[0] mid-packet does not revoke the grant.
- Two VCs, two owners: port 0 owns VC0 and port 3 owns VC1, both valid each cycle with i_free=1.
  - Required: o_vc_select alternates 01/10 and o_port_select alternates 00001/01000.
  - Required: if port 3 stalls (free=0), the link stays on VC1 until free.
- Spurious tail: a non-owner port asserts end_of_packet on VC0 during port 1's packet.
  - Required: grant unchanged; release happens only on port 1's tail.
- Reset mid-packet: assert rst_n=0 while VC0 and VC1 are BUSY.
  - Required: o_grant=0 immediately.
  - Required: after release, simultaneous requests from ports 0 and 4 on VC0 are granted to port 0 first.
